mult_div_unit: RTL and testbench

- Multi-cycle multiply/divide unit owning the HI/LO register pair of the 32-bit MIPS datapath.
- Executes MULT, MULTU, DIV and DIVU issued by the decode/ALU stage, and supports MTHI/MTLO writes.
- Drives hi/lo continuously, so the ALU result mux serves MFHI/MFLO directly.
- Radix-2 iterative core: one shift-add (multiply) or restoring subtract (divide) step per clock.

---
 rtl/mult_div_unit.sv | 141 ++++++++++++++
 tb/tb_mult_div_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - radix-2 iterative MULT/MULTU/DIV/DIVU unit owning HI/LO.
// Optional MDU_DIV0_FLAG_EN adds a div_zero pulse alongside done.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
`ifdef MDU_DIV0_FLAG_EN
  ,
  output logic             div_zero
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt;
  logic             is_div, neg_lo, neg_hi, div0;
  logic [WIDTH-1:0] m, q;
  logic [WIDTH:0]   acc;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     add_sum, rem_shift, rem_diff;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  // Signed ops work on magnitudes; the sign is restored in FIX.
  assign a_mag = (!op[0] && a[WIDTH-1]) ? -a : a;
  assign b_mag = (!op[0] && b[WIDTH-1]) ? -b : b;

  assign add_sum   = {1'b0, acc[WIDTH-1:0]} + {1'b0, m};
  assign rem_shift = {acc[WIDTH-1:0], q[WIDTH-1]};
  assign rem_diff  = rem_shift - {1'b0, m};

  assign prod     = {acc[WIDTH-1:0], q};
  assign prod_fix = neg_lo ? -prod : prod;
  assign quot_fix = neg_lo ? -q : q;
  assign rem_fix  = neg_hi ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (cnt == CW'(WIDTH - 1)) state_n = FIX;
      FIX:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      is_div <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      div0   <= 1'b0;
      m      <= '0;
      q      <= '0;
      acc    <= '0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
`ifdef MDU_DIV0_FLAG_EN
      div_zero <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef MDU_DIV0_FLAG_EN
      div_zero <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (start) begin
            is_div <= op[1];
            neg_lo <= !op[0] && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_hi <= !op[0] && a[WIDTH-1];
            div0   <= op[1] && (b == '0);
            m      <= b_mag;
            q      <= a_mag;
            acc    <= '0;
            cnt    <= '0;
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (is_div) begin
            // Restoring step: keep the difference only when it did not borrow.
            if (!rem_diff[WIDTH]) begin
              acc <= rem_diff;
              q   <= {q[WIDTH-2:0], 1'b1};
            end else begin
              acc <= rem_shift;
              q   <= {q[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc <= q[0] ? {1'b0, add_sum[WIDTH:1]} : {1'b0, acc[WIDTH:1]};
            q   <= {(q[0] ? add_sum[0] : acc[0]), q[WIDTH-1:1]};
          end
        end
        FIX: begin
          done <= 1'b1;
          if (is_div) begin
            // Divide by zero leaves remainder = dividend naturally; only LO is forced.
            lo <= div0 ? '1 : quot_fix;
            hi <= rem_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
`ifdef MDU_DIV0_FLAG_EN
          div_zero <= div0;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - scoreboard bench for mult_div_unit with a 64-bit arithmetic reference model.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        hi_we, lo_we;
  logic        busy, done;
  logic [31:0] hi, lo;
`ifdef MDU_DIV0_FLAG_EN
  logic        div_zero;
`endif

  int checks = 0;
  int errors = 0;
  logic [64:0] exp_q[$];
  logic [64:0] mon_e;
  int          lat;
  logic        busy_bad;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
`ifdef MDU_DIV0_FLAG_EN
    , .div_zero(div_zero)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: {div_zero, hi, lo} from plain 64-bit arithmetic.
  function automatic logic [64:0] ref_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy, sp, sq, sr;
    logic [63:0] ux, uy, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    case (o)
      2'd0: begin sp = sx * sy; r = sp; end
      2'd1: r = ux * uy;
      default: begin
        if (y == 32'd0) r = {x, 32'hFFFF_FFFF};
        else if (o == 2'd2) begin
          sq = sx / sy;
          sr = sx % sy;
          r = {sr[31:0], sq[31:0]};
        end else begin
          r = {(x % y), (x / y)};
        end
      end
    endcase
    return {(o[1] && y == 32'd0), r};
  endfunction

  // Caller is between edges with the DUT idle; returns #1 after the accepting edge.
  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    exp_q.push_back(ref_model(o, x, y));
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
  endtask

  task automatic wait_done(output int edges);
    edges = 1;
    busy_bad = 1'b0;
    while (!done && edges < 200) begin
      if (!busy) busy_bad = 1'b1;
      @(posedge clk); #1;
      edges++;
    end
    chk("done_seen", {63'b0, done}, 64'd1);
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    launch(o, x, y);
    wait_done(lat);
    chk("latency", lat, 64'd34);
    chk("busy_during_op", {63'b0, busy_bad}, 64'd0);
    chk("busy_at_done", {63'b0, busy}, 64'd0);
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", {63'b0, done}, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("result_hi_lo", {hi, lo}, mon_e[63:0]);
`ifdef MDU_DIV0_FLAG_EN
        chk("div_zero", {63'b0, div_zero}, {63'b0, mon_e[64]});
`endif
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0]  o;
    logic [31:0] x, y;
    rst = 1'b1; start = 1'b0; op = 2'd0; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {63'b0, busy}, 64'd0);
    chk("reset_done", {63'b0, done}, 64'd0);
    chk("reset_hi_lo", {hi, lo}, 64'd0);
    rst = 1'b0;

    run_op(2'd0, 32'hFFFF_FFFD, 32'd7);
    chk("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("mult_m1m1", {hi, lo}, 64'h0000_0000_0000_0001);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2);
    chk("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(2'd3, 32'd100, 32'd7);
    chk("divu", {hi, lo}, {32'd2, 32'd14});
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_overflow", {hi, lo}, 64'h0000_0000_8000_0000);
    run_op(2'd3, 32'h1234, 32'd0);
    chk("divu_by_zero", {hi, lo}, 64'h0000_1234_FFFF_FFFF);
    run_op(2'd2, 32'hFFFF_FFFB, 32'd0);
    chk("div_by_zero", {hi, lo}, 64'hFFFF_FFFB_FFFF_FFFF);

    // Second start and MTHI while busy must both be ignored.
    @(negedge clk);
    launch(2'd3, 32'd1000, 32'd7);
    repeat (8) @(posedge clk);
    #1;
    start = 1'b1; op = 2'd0; a = 32'd5; b = 32'd5; hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0;
    wait_done(lat);
    chk("ignore_midop", {hi, lo}, {32'd6, 32'd142});

    // Start on the done cycle is accepted.
    launch(2'd1, 32'h0001_0000, 32'h0001_0000);
    chk("b2b_busy", {63'b0, busy}, 64'd1);
    wait_done(lat);
    chk("b2b_latency", lat, 64'd34);
    chk("b2b_result", {hi, lo}, 64'h0000_0001_0000_0000);

    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 5))
        0: y = 32'd0;
        1: y = $urandom_range(1, 15);
        2: x = 32'h8000_0000;
        3: y = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_op(o, x, y);
    end

    // Reset mid-operation aborts with no writeback.
    @(negedge clk);
    launch(2'd3, 32'hFFFF_0000, 32'd3);
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_busy", {63'b0, busy}, 64'd0);
    chk("abort_hi_lo", {hi, lo}, 64'd0);
    void'(exp_q.pop_back());
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("abort_no_done", {63'b0, done}, 64'd0);

    // MTHI / MTLO / both.
    hi_we = 1'b1; wdata = 32'h1111_2222;
    @(posedge clk); #1;
    hi_we = 1'b0;
    chk("mthi", {hi, lo}, 64'h1111_2222_0000_0000);
    @(negedge clk);
    lo_we = 1'b1; wdata = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    lo_we = 1'b0;
    chk("mtlo", {hi, lo}, 64'h1111_2222_A5A5_A5A5);
    @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0BAD_F00D;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    chk("mthi_mtlo", {hi, lo}, 64'h0BAD_F00D_0BAD_F00D);
    @(negedge clk);
    hi_we = 1'b1; start = 1'b1; op = 2'd1; a = 32'd3; b = 32'd3; wdata = 32'h5555_5555;
    exp_q.push_back(ref_model(2'd1, 32'd3, 32'd3));
    @(posedge clk); #1;
    hi_we = 1'b0; start = 1'b0;
    wait_done(lat);
    chk("mthi_with_start", {hi, lo}, 64'd9);

    repeat (5) @(negedge clk);
    chk("queue_drained", exp_q.size(), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
